// File: rtl/lc3_ctrl_pkg.sv
// Shared encodings for the LC-3 multi-cycle control unit: state codes, opcodes,
// datapath mux selects and the control word driven toward the datapath.
package lc3_ctrl_pkg;

    localparam logic [4:0] ST_IDLE = 5'd0;
    localparam logic [4:0] ST_F1   = 5'd1;
    localparam logic [4:0] ST_F2   = 5'd2;
    localparam logic [4:0] ST_F3   = 5'd3;
    localparam logic [4:0] ST_DEC  = 5'd4;
    localparam logic [4:0] ST_ALU  = 5'd5;
    localparam logic [4:0] ST_BR   = 5'd6;
    localparam logic [4:0] ST_JMP  = 5'd7;
    localparam logic [4:0] ST_LEA  = 5'd8;
    localparam logic [4:0] ST_LDA  = 5'd9;
    localparam logic [4:0] ST_RD   = 5'd10;
    localparam logic [4:0] ST_WB   = 5'd11;
    localparam logic [4:0] ST_STA  = 5'd12;
    localparam logic [4:0] ST_SMDR = 5'd13;
    localparam logic [4:0] ST_WR   = 5'd14;
    localparam logic [4:0] ST_HALT = 5'd15;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {
        ALUK_ADD   = 2'b00,
        ALUK_AND   = 2'b01,
        ALUK_NOT   = 2'b10,
        ALUK_PASSA = 2'b11
    } aluk_e;

    typedef enum logic [1:0] {
        PCMUX_INC   = 2'b00,
        PCMUX_BUS   = 2'b01,
        PCMUX_ADDER = 2'b10
    } pcmux_e;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'b00,
        ADDR2_OFF6  = 2'b01,
        ADDR2_OFF9  = 2'b10,
        ADDR2_OFF11 = 2'b11
    } addr2mux_e;

    typedef enum logic [1:0] {
        SR1_IR11 = 2'b00,
        SR1_IR8  = 2'b01,
        SR1_R6   = 2'b10
    } sr1mux_e;

    typedef enum logic [1:0] {
        DR_IR11 = 2'b00,
        DR_R6   = 2'b01,
        DR_R7   = 2'b10
    } drmux_e;

    typedef struct packed {
        logic      ld_mar;
        logic      ld_mdr;
        logic      ld_ir;
        logic      ld_pc;
        logic      ld_reg;
        logic      ld_cc;
        logic      gate_pc;
        logic      gate_mdr;
        logic      gate_alu;
        logic      gate_marmux;
        pcmux_e    pcmux;
        logic      addr1mux;
        addr2mux_e addr2mux;
        logic      marmux;
        sr1mux_e   sr1mux;
        drmux_e    drmux;
        aluk_e     aluk;
        logic      mio_en;
        logic      r_w;
        logic      halted;
    } ctrl_t;

    // LDR/STR form their address from a base register rather than the PC.
    function automatic logic is_base_mode(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Combinational control-word decode: maps the current state plus IR/NZP onto
// every load enable, bus gate, mux select and memory strobe.
module lc3_ctrl_decode
    import lc3_ctrl_pkg::*;
(
    input  logic [4:0]  state_i,
    input  logic [15:0] ir_i,
    input  logic [2:0]  nzp_i,
    output ctrl_t       ctrl_o
);

    logic [3:0] op;
    logic       ben;
    logic       unused_ir;

    assign op        = ir_i[15:12];
    assign ben       = |(ir_i[11:9] & nzp_i);
    assign unused_ir = ^ir_i[8:0];

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_F1: begin
                ctrl_o.gate_pc = 1'b1;
                ctrl_o.ld_mar  = 1'b1;
                ctrl_o.ld_pc   = 1'b1;
                ctrl_o.pcmux   = PCMUX_INC;
            end
            ST_F2, ST_RD: begin
                ctrl_o.mio_en = 1'b1;
                ctrl_o.r_w    = 1'b0;
                ctrl_o.ld_mdr = 1'b1;
            end
            ST_F3: begin
                ctrl_o.gate_mdr = 1'b1;
                ctrl_o.ld_ir    = 1'b1;
            end
            ST_ALU: begin
                ctrl_o.sr1mux   = SR1_IR8;
                ctrl_o.drmux    = DR_IR11;
                ctrl_o.gate_alu = 1'b1;
                ctrl_o.ld_reg   = 1'b1;
                ctrl_o.ld_cc    = 1'b1;
                case (op)
                    OP_AND:  ctrl_o.aluk = ALUK_AND;
                    OP_NOT:  ctrl_o.aluk = ALUK_NOT;
                    default: ctrl_o.aluk = ALUK_ADD;
                endcase
            end
            ST_BR: begin
                if (ben) begin
                    ctrl_o.pcmux    = PCMUX_ADDER;
                    ctrl_o.addr1mux = 1'b0;
                    ctrl_o.addr2mux = ADDR2_OFF9;
                    ctrl_o.ld_pc    = 1'b1;
                end
            end
            ST_JMP: begin
                ctrl_o.sr1mux   = SR1_IR8;
                ctrl_o.addr1mux = 1'b1;
                ctrl_o.addr2mux = ADDR2_ZERO;
                ctrl_o.pcmux    = PCMUX_ADDER;
                ctrl_o.ld_pc    = 1'b1;
            end
            ST_LEA: begin
                ctrl_o.addr1mux    = 1'b0;
                ctrl_o.addr2mux    = ADDR2_OFF9;
                ctrl_o.marmux      = 1'b1;
                ctrl_o.gate_marmux = 1'b1;
                ctrl_o.drmux       = DR_IR11;
                ctrl_o.ld_reg      = 1'b1;
            end
            ST_LDA, ST_STA: begin
                ctrl_o.marmux      = 1'b1;
                ctrl_o.gate_marmux = 1'b1;
                ctrl_o.ld_mar      = 1'b1;
                if (is_base_mode(op)) begin
                    ctrl_o.sr1mux   = SR1_IR8;
                    ctrl_o.addr1mux = 1'b1;
                    ctrl_o.addr2mux = ADDR2_OFF6;
                end else begin
                    ctrl_o.addr1mux = 1'b0;
                    ctrl_o.addr2mux = ADDR2_OFF9;
                end
            end
            ST_WB: begin
                ctrl_o.gate_mdr = 1'b1;
                ctrl_o.drmux    = DR_IR11;
                ctrl_o.ld_reg   = 1'b1;
                ctrl_o.ld_cc    = 1'b1;
            end
            // Store data travels SR (IR[11:9]) -> ALU pass-through -> MDR.
            ST_SMDR: begin
                ctrl_o.sr1mux   = SR1_IR11;
                ctrl_o.aluk     = ALUK_PASSA;
                ctrl_o.gate_alu = 1'b1;
                ctrl_o.ld_mdr   = 1'b1;
            end
            ST_WR: begin
                ctrl_o.mio_en = 1'b1;
                ctrl_o.r_w    = 1'b1;
            end
            ST_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 multi-cycle control unit: state register, next-state sequencing with
// ready-handshaked memory phases, and the retired-instruction counter.
module lc3_control_unit
    import lc3_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_RUN,
    input  logic [15:0]      i_IR,
    input  logic [2:0]       i_NZP,
    input  logic             i_MEM_R,
    output logic             o_LD_MAR,
    output logic             o_LD_MDR,
    output logic             o_LD_IR,
    output logic             o_LD_PC,
    output logic             o_LD_REG,
    output logic             o_LD_CC,
    output logic             o_GATE_PC,
    output logic             o_GATE_MDR,
    output logic             o_GATE_ALU,
    output logic             o_GATE_MARMUX,
    output logic [1:0]       o_PCMUX,
    output logic             o_ADDR1MUX,
    output logic [1:0]       o_ADDR2MUX,
    output logic             o_MARMUX,
    output logic [1:0]       o_SR1MUX,
    output logic [1:0]       o_DRMUX,
    output logic [1:0]       o_ALUK,
    output logic             o_MIO_EN,
    output logic             o_R_W,
    output logic             o_HALTED,
    output logic [4:0]       o_STATE,
    output logic [CNT_W-1:0] o_INSTR_CNT
);

    logic [4:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    ctrl_t            ctrl;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: if (i_RUN) state_d = ST_F1;
            ST_F1:   state_d = ST_F2;
            ST_F2:   if (i_MEM_R) state_d = ST_F3;
            ST_F3:   state_d = ST_DEC;
            ST_DEC: begin
                case (i_IR[15:12])
                    OP_ADD, OP_AND, OP_NOT: state_d = ST_ALU;
                    OP_BR:                  state_d = ST_BR;
                    OP_JMP:                 state_d = ST_JMP;
                    OP_LEA:                 state_d = ST_LEA;
                    OP_LD, OP_LDR:          state_d = ST_LDA;
                    OP_ST, OP_STR:          state_d = ST_STA;
                    default:                state_d = ST_HALT;
                endcase
            end
            ST_ALU, ST_BR, ST_JMP, ST_LEA, ST_WB: begin
                state_d = ST_F1;
                retire  = 1'b1;
            end
            ST_LDA:  state_d = ST_RD;
            ST_RD:   if (i_MEM_R) state_d = ST_WB;
            ST_STA:  state_d = ST_SMDR;
            ST_SMDR: state_d = ST_WR;
            ST_WR: begin
                if (i_MEM_R) begin
                    state_d = ST_F1;
                    retire  = 1'b1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    lc3_ctrl_decode u_decode (
        .state_i (state_q),
        .ir_i    (i_IR),
        .nzp_i   (i_NZP),
        .ctrl_o  (ctrl)
    );

    assign o_LD_MAR      = ctrl.ld_mar;
    assign o_LD_MDR      = ctrl.ld_mdr;
    assign o_LD_IR       = ctrl.ld_ir;
    assign o_LD_PC       = ctrl.ld_pc;
    assign o_LD_REG      = ctrl.ld_reg;
    assign o_LD_CC       = ctrl.ld_cc;
    assign o_GATE_PC     = ctrl.gate_pc;
    assign o_GATE_MDR    = ctrl.gate_mdr;
    assign o_GATE_ALU    = ctrl.gate_alu;
    assign o_GATE_MARMUX = ctrl.gate_marmux;
    assign o_PCMUX       = ctrl.pcmux;
    assign o_ADDR1MUX    = ctrl.addr1mux;
    assign o_ADDR2MUX    = ctrl.addr2mux;
    assign o_MARMUX      = ctrl.marmux;
    assign o_SR1MUX      = ctrl.sr1mux;
    assign o_DRMUX       = ctrl.drmux;
    assign o_ALUK        = ctrl.aluk;
    assign o_MIO_EN      = ctrl.mio_en;
    assign o_R_W         = ctrl.r_w;
    assign o_HALTED      = ctrl.halted;
    assign o_STATE       = state_q;
    assign o_INSTR_CNT   = cnt_q;

endmodule
